// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, registered syncs, blanking and gated colour,
// line/frame strobes and pixel-replicated framebuffer coordinates.
module vga_timing_gen #(
  parameter int unsigned HW         = 640,
  parameter int unsigned HF         = 16,
  parameter int unsigned HS         = 96,
  parameter int unsigned HB         = 48,
  parameter int unsigned VW         = 480,
  parameter int unsigned VF         = 10,
  parameter int unsigned VS         = 2,
  parameter int unsigned VB         = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned RW         = 3,
  parameter int unsigned GW         = 3,
  parameter int unsigned BW         = 2,
  parameter int unsigned CW         = 10,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int unsigned FCW        = 7,
  parameter int unsigned FRW        = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PIX_EN,
  input  logic [RW-1:0]        RED,
  input  logic [GW-1:0]        GREEN,
  input  logic [BW-1:0]        BLUE,
  output logic [CW-1:0]        ROW,
  output logic [CW-1:0]        COLUMN,
  output logic [FRW-1:0]       FB_ROW,
  output logic [FCW-1:0]       FB_COL,
  output logic [FRW+FCW-1:0]   FB_ADDR,
  output logic [RW-1:0]        ROUT,
  output logic [GW-1:0]        GOUT,
  output logic [BW-1:0]        BOUT,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic                 BLANK,
  output logic                 LINE_START,
  output logic                 FRAME_START
);

  localparam int unsigned HC = HW + HF + HS + HB;
  localparam int unsigned VC = VW + VF + VS + VB;
  localparam logic [CW-1:0] HLast = CW'(HC - 1);
  localparam logic [CW-1:0] VLast = CW'(VC - 1);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [31:0]   h_w, v_w;
  logic          active, hsync_d, vsync_d;
  logic [RW-1:0] rout_q;
  logic [GW-1:0] gout_q;
  logic [BW-1:0] bout_q;
  logic          hsync_q, vsync_q, blank_q, line_start_q, frame_start_q;

  // Compare in 32 bits so sync/blank bounds equal to 2^CW cannot alias to zero.
  assign h_w = 32'(h_q);
  assign v_w = 32'(v_q);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (PIX_EN) begin
      if (h_q != HLast) begin
        h_d = h_q + 1'b1;
      end else begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end
    end
  end

  always_comb begin
    active  = (h_w < HW) && (v_w < VW);
    hsync_d = ((h_w >= HW + HF) && (h_w < HW + HF + HS)) ? HS_POL : ~HS_POL;
    vsync_d = ((v_w >= VW + VF) && (v_w < VW + VF + VS)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_q           <= '0;
      v_q           <= '0;
      rout_q        <= '0;
      gout_q        <= '0;
      bout_q        <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      // Strobes run every CLK so a sparse PIX_EN still yields a single-cycle pulse.
      line_start_q  <= PIX_EN && (h_q == '0);
      frame_start_q <= PIX_EN && (h_q == '0) && (v_q == '0);
      if (PIX_EN) begin
        rout_q  <= active ? RED : '0;
        gout_q  <= active ? GREEN : '0;
        bout_q  <= active ? BLUE : '0;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        blank_q <= ~active;
      end
    end
  end

  assign ROW         = v_q;
  assign COLUMN      = h_q;
  assign FB_ROW      = FRW'(v_q >> SCALE_LOG2);
  assign FB_COL      = FCW'(h_q >> SCALE_LOG2);
  assign FB_ADDR     = {FB_ROW, FB_COL};
  assign ROUT        = rout_q;
  assign GOUT        = gout_q;
  assign BOUT        = bout_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign BLANK       = blank_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

endmodule
